// File: rtl/jpeg_dc_huff_enc_pkg.sv
// Shared types for the luma DC Huffman encoder: FSM states, widths and the
// standard Y DC code table (category -> code bits and code length).
package jpeg_dc_huff_enc_pkg;

    localparam int ACC_W = 32;
    localparam int CNT_W = 6;
    localparam int SYM_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_STUFF = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] width;
        logic [8:0] bits;
    } dc_code_t;

    // Code bits are right-aligned; width gives how many of them are sent.
    function automatic dc_code_t dc_code(input logic [3:0] cat);
        dc_code_t c;
        case (cat)
            4'd0:    c = '{width: 4'd2, bits: 9'b000000000};
            4'd1:    c = '{width: 4'd3, bits: 9'b000000010};
            4'd2:    c = '{width: 4'd3, bits: 9'b000000011};
            4'd3:    c = '{width: 4'd3, bits: 9'b000000100};
            4'd4:    c = '{width: 4'd3, bits: 9'b000000101};
            4'd5:    c = '{width: 4'd3, bits: 9'b000000110};
            4'd6:    c = '{width: 4'd4, bits: 9'b000001110};
            4'd7:    c = '{width: 4'd5, bits: 9'b000011110};
            4'd8:    c = '{width: 4'd6, bits: 9'b000111110};
            4'd9:    c = '{width: 4'd7, bits: 9'b001111110};
            4'd10:   c = '{width: 4'd8, bits: 9'b011111110};
            4'd11:   c = '{width: 4'd9, bits: 9'b111111110};
            default: c = '{width: 4'd0, bits: 9'b000000000};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/jpeg_dc_huff_enc_table.sv
// Combinational DC difference classifier: magnitude category plus the
// matching Huffman code from the standard luma DC table.
module jpeg_dc_huff_enc_table
    import jpeg_dc_huff_enc_pkg::*;
(
    input  logic [11:0] diff_i,
    output logic [3:0]  cat_o,
    output logic [8:0]  code_o,
    output logic [3:0]  code_w_o
);

    logic [11:0] mag;
    dc_code_t    code;

    always_comb begin
        mag = diff_i[11] ? (12'd0 - diff_i) : diff_i;
        // Category is the position of the highest set magnitude bit.
        cat_o = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) cat_o = 4'(i + 1);
        end
        code     = dc_code(cat_o);
        code_o   = code.bits;
        code_w_o = code.width;
    end

endmodule

// File: rtl/jpeg_dc_huff_enc.sv
// Luma DC Huffman encoder: DPCM predictor, symbol formation, MSB-first byte
// packer. `JPEG_DC_ENC_STUFF_EN inserts 0x00 after every emitted 0xFF.
module jpeg_dc_huff_enc
    import jpeg_dc_huff_enc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport_valid_i,
    input  logic [10:0] inport_dc_i,
    output logic        inport_accept_o,
    input  logic        restart_i,
    input  logic        flush_i,
    output logic        outport_valid_o,
    output logic [7:0]  outport_data_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i,
    output logic        idle_o
);

    state_t             state_q, state_d;
    logic [10:0]        pred_q, pred_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               last_flag_q, last_flag_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic               accept_q, accept_d;
    logic               idle_q, idle_d;

    logic [11:0]        diff;
    logic [3:0]         cat;
    logic [8:0]         code;
    logic [3:0]         code_w;
    logic [11:0]        amp_src;
    logic [SYM_W-1:0]   amp_mask;
    logic [SYM_W-1:0]   sym;
    logic [SYM_W-1:0]   sym_la;
    logic [4:0]         sym_len;
    logic [ACC_W-1:0]   sym_acc;
    logic [ACC_W-1:0]   pad;
    logic               transfer;

    jpeg_dc_huff_enc_table u_table (
        .diff_i   (diff),
        .cat_o    (cat),
        .code_o   (code),
        .code_w_o (code_w)
    );

    always_comb begin
        diff     = {inport_dc_i[10], inport_dc_i} - {pred_q[10], pred_q};
        // Negative differences send the low bits of diff-1 (ones' complement).
        amp_src  = diff - {11'd0, diff[11]};
        amp_mask = (20'd1 << cat) - 20'd1;
        sym      = ({11'd0, code} << cat) | ({8'd0, amp_src} & amp_mask);
        sym_len  = {1'b0, code_w} + {1'b0, cat};
        sym_la   = sym << (5'd20 - sym_len);
        // The accumulator is MSB-aligned; bits below the fill count stay zero.
        sym_acc  = {sym_la, 12'd0} >> cnt_q;
        pad      = (32'hFF00_0000 >> cnt_q) & 32'hFF00_0000;
        transfer = inport_valid_i & accept_q;

        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | flush_i;
        last_flag_d  = last_flag_q;
        pred_d       = transfer ? inport_dc_i : pred_q;
        if (restart_i) pred_d = 11'd0;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    acc_d = acc_q | sym_acc;
                    cnt_d = cnt_q + {1'b0, sym_len};
                    if (cnt_d >= 6'd8) state_d = ST_EMIT;
                end else if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    if (cnt_q != 6'd0) begin
                        acc_d       = acc_q | pad;
                        cnt_d       = 6'd8;
                        last_flag_d = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (outport_accept_i) begin
                    acc_d   = acc_q << 8;
                    cnt_d   = cnt_q - 6'd8;
                    state_d = (cnt_d >= 6'd8) ? ST_EMIT : ST_IDLE;
`ifdef JPEG_DC_ENC_STUFF_EN
                    if (acc_q[31:24] == 8'hFF) state_d = ST_STUFF;
`endif
                end
            end
`ifdef JPEG_DC_ENC_STUFF_EN
            ST_STUFF: begin
                if (outport_accept_i) state_d = (cnt_q >= 6'd8) ? ST_EMIT : ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) last_flag_d = 1'b0;

        // Outputs are registered from next-state values so they line up with state_q.
        valid_d  = (state_d != ST_IDLE);
        data_d   = (state_d == ST_EMIT) ? acc_d[31:24] : 8'h00;
`ifdef JPEG_DC_ENC_STUFF_EN
        last_d   = (state_d == ST_EMIT) ? (last_flag_d && (acc_d[31:24] != 8'hFF))
                                        : ((state_d == ST_STUFF) && last_flag_d);
`else
        last_d   = (state_d == ST_EMIT) && last_flag_d;
`endif
        accept_d = (state_d == ST_IDLE) && (cnt_d < 6'd8) && !flush_pend_d;
        idle_d   = (state_d == ST_IDLE) && (cnt_d == 6'd0) && !flush_pend_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            pred_q       <= 11'd0;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            last_flag_q  <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= 8'h00;
            last_q       <= 1'b0;
            accept_q     <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            last_flag_q  <= last_flag_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            last_q       <= last_d;
            accept_q     <= accept_d;
            idle_q       <= idle_d;
        end
    end

    assign inport_accept_o = accept_q;
    assign outport_valid_o = valid_q;
    assign outport_data_o  = data_q;
    assign outport_last_o  = last_q;
    assign idle_o          = idle_q;

endmodule
